// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: ALU opcodes, sequencer state encoding
// and the default register-file geometry.
package cpu_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_SEL_W    = 5;
    localparam int unsigned ALU_OP_W     = 8;

    localparam logic [ALU_OP_W-1:0] ALU_NOP = 8'h00;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 8'h01;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 8'h02;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 8'h03;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 8'h04;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 8'h05;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEED  = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: steps the register file, operand muxes, ALU and bus
// buffer through CLEAR / SEED / ADD ops, writing one term per register.
module fib_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter int unsigned SEL_W     = DEF_SEL_W,
    parameter int unsigned NUM_TERMS = NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                step_mode,
    input  logic                step,
    input  logic                loop,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [SEL_W-1:0]    muxA,
    output logic [SEL_W-1:0]    muxB,
    output logic [NUM_REGS-1:0] regs_en,
    output logic [DATA_W-1:0]   imm,
    output logic                imm_control,
    output logic                buff_en,
    output logic                busy,
    output logic                done,
    output logic [SEL_W-1:0]    term_idx
);

    if (NUM_TERMS < 3 || NUM_TERMS > NUM_REGS || NUM_REGS > (32'd1 << SEL_W)) begin : g_bad_params
        $error("fib_seq_ctrl: need 3 <= NUM_TERMS <= NUM_REGS <= 2**SEL_W");
    end

    localparam logic [SEL_W-1:0] LAST_K = SEL_W'(NUM_TERMS - 1);

    seq_state_e          state_q, state_d;
    logic [SEL_W-1:0]    k_q, k_d;
    logic                go_q, go_d;

    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [SEL_W-1:0]    mux_a_q, mux_a_d;
    logic [SEL_W-1:0]    mux_b_q, mux_b_d;
    logic [NUM_REGS-1:0] regs_en_q, regs_en_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                imm_ctrl_q, imm_ctrl_d;
    logic                buff_en_q, buff_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [SEL_W-1:0]    term_q, term_d;

    // go marks a cycle that commits its write; in step mode it is armed by step.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        go_d    = go_q;
        case (state_q)
            ST_IDLE: begin
                go_d = 1'b0;
                if (start) begin
                    state_d = ST_CLEAR;
                    k_d     = '0;
                    go_d    = !step_mode;
                end
            end
            ST_CLEAR: begin
                go_d = !step_mode || step;
                if (go_q) begin
                    state_d = ST_SEED;
                    k_d     = SEL_W'(1);
                end
            end
            ST_SEED: begin
                go_d = !step_mode || step;
                if (go_q) begin
                    state_d = ST_ADD;
                    k_d     = SEL_W'(2);
                end
            end
            ST_ADD: begin
                go_d = !step_mode || step;
                if (go_q) begin
                    if (k_q == LAST_K) begin
                        state_d = ST_DONE;
                        go_d    = 1'b0;
                    end else begin
                        k_d = k_q + SEL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                go_d = 1'b0;
                if (start || loop) begin
                    state_d = ST_CLEAR;
                    k_d     = '0;
                    go_d    = !step_mode;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
                go_d    = 1'b0;
            end
        endcase
    end

    // Output values for the upcoming state, so every output leaves a flop.
    always_comb begin
        alu_op_d   = '0;
        mux_a_d    = '0;
        mux_b_d    = '0;
        regs_en_d  = '0;
        imm_d      = '0;
        imm_ctrl_d = 1'b0;
        buff_en_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        term_d     = '0;
        case (state_d)
            ST_CLEAR, ST_SEED, ST_ADD: begin
                alu_op_d  = ALU_ADD;
                buff_en_d = 1'b1;
                busy_d    = 1'b1;
                term_d    = k_d;
                regs_en_d = go_d ? (NUM_REGS'(1) << k_d) : '0;
                if (state_d == ST_ADD) begin
                    mux_a_d = k_d - SEL_W'(2);
                    mux_b_d = k_d - SEL_W'(1);
                end else begin
                    imm_ctrl_d = 1'b1;
                    imm_d      = (state_d == ST_SEED) ? DATA_W'(1) : '0;
                end
            end
            ST_DONE: begin
                alu_op_d  = ALU_ADD;
                mux_a_d   = LAST_K;
                buff_en_d = 1'b1;
                done_d    = 1'b1;
                term_d    = k_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            go_q       <= 1'b0;
            alu_op_q   <= '0;
            mux_a_q    <= '0;
            mux_b_q    <= '0;
            regs_en_q  <= '0;
            imm_q      <= '0;
            imm_ctrl_q <= 1'b0;
            buff_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            term_q     <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            go_q       <= go_d;
            alu_op_q   <= alu_op_d;
            mux_a_q    <= mux_a_d;
            mux_b_q    <= mux_b_d;
            regs_en_q  <= regs_en_d;
            imm_q      <= imm_d;
            imm_ctrl_q <= imm_ctrl_d;
            buff_en_q  <= buff_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            term_q     <= term_d;
        end
    end

    assign alu_op      = alu_op_q;
    assign muxA        = mux_a_q;
    assign muxB        = mux_b_q;
    assign regs_en     = regs_en_q;
    assign imm         = imm_q;
    assign imm_control = imm_ctrl_q;
    assign buff_en     = buff_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign term_idx    = term_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Scoreboard bench for fib_seq_ctrl: a 16-term and a 5-term instance, each
// observed against a register-file/ALU model and queued expected events.
module tb_fib_seq_ctrl;
    import cpu_pkg::*;

    localparam int NT0 = 16;
    localparam int NT1 = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, step_mode = 1'b0, step = 1'b0, loop = 1'b0;
    logic start1 = 1'b0, loop1 = 1'b0;

    logic [7:0]  alu_op0;
    logic [4:0]  mux_a0, mux_b0, term0;
    logic [15:0] regs_en0, imm0;
    logic        imm_ctrl0, buff_en0, busy0, done0;

    logic [7:0]  alu_op1;
    logic [2:0]  mux_a1, mux_b1, term1;
    logic [7:0]  regs_en1, imm1;
    logic        imm_ctrl1, buff_en1, busy1, done1;

    fib_seq_ctrl #(.DATA_W(16), .NUM_REGS(16), .SEL_W(5), .NUM_TERMS(NT0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step), .loop(loop),
        .alu_op(alu_op0), .muxA(mux_a0), .muxB(mux_b0), .regs_en(regs_en0), .imm(imm0),
        .imm_control(imm_ctrl0), .buff_en(buff_en0), .busy(busy0), .done(done0), .term_idx(term0)
    );

    fib_seq_ctrl #(.DATA_W(8), .NUM_REGS(8), .SEL_W(3), .NUM_TERMS(NT1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .step_mode(step_mode), .step(step), .loop(loop1),
        .alu_op(alu_op1), .muxA(mux_a1), .muxB(mux_b1), .regs_en(regs_en1), .imm(imm1),
        .imm_control(imm_ctrl1), .buff_en(buff_en1), .busy(busy1), .done(done1), .term_idx(term1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_done;
        int regs_en;
        int mux_a;
        int mux_b;
        int imm;
        int imm_ctrl;
        int term;
        int bus;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   rf[2][16];
    logic done_prev0 = 1'b0, done_prev1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fib(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int mask(input int d);
        return (d == 0) ? 32'hFFFF : 32'hFF;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    task automatic chk(input int d, input string name, input int act, input int expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", d, name, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) exp0.push_back(e);
        else        exp1.push_back(e);
    endtask

    // Write j: R[j] <- fib(j); CLEAR/SEED take B from imm, ADD from R[j-2]+R[j-1].
    task automatic push_write(input int d, input int j, input int t);
        exp_t e;
        e.cyc      = t;
        e.is_done  = 1'b0;
        e.regs_en  = 1 << j;
        e.mux_a    = (j < 2) ? 0 : j - 2;
        e.mux_b    = (j < 2) ? 0 : j - 1;
        e.imm      = (j == 1) ? 1 : 0;
        e.imm_ctrl = (j < 2) ? 1 : 0;
        e.term     = j;
        e.bus      = fib(j) & mask(d);
        push_exp(d, e);
    endtask

    task automatic push_done(input int d, input int n, input int t);
        exp_t e;
        e.cyc      = t;
        e.is_done  = 1'b1;
        e.regs_en  = 0;
        e.mux_a    = n - 1;
        e.mux_b    = 0;
        e.imm      = 0;
        e.imm_ctrl = 0;
        e.term     = n - 1;
        e.bus      = fib(n - 1) & mask(d);
        push_exp(d, e);
    endtask

    task automatic push_run(input int d, input int n, input int first);
        for (int j = 0; j < n; j++) push_write(d, j, first + j);
        push_done(d, n, first + n);
    endtask

    // Monitor step: datapath model plus scoreboard pop on writes and done rises.
    task automatic mon(input int d, input int ren, input int ma, input int mb, input int im,
                       input int ic, input int be, input int ao, input int bz, input int dn,
                       input int dn_prev, input int ti);
        exp_t e;
        int a_val, b_val, bus;
        a_val = (ma < 16) ? rf[d][ma] : 0;
        b_val = (ic != 0) ? im : ((mb < 16) ? rf[d][mb] : 0);
        bus   = (a_val + b_val) & mask(d);
        if (ren != 0 || (dn != 0 && dn_prev == 0)) begin
            if (qsize(d) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut%0d unexpected_event: cycle %0d regs_en=%0h done=%0d, expected no activity",
                         d, cyc, ren, dn);
            end else begin
                e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
                chk(d, "event_cycle", cyc, e.cyc);
                chk(d, "regs_en", ren, e.regs_en);
                chk(d, "muxA", ma, e.mux_a);
                chk(d, "muxB", mb, e.mux_b);
                chk(d, "imm", im, e.imm);
                chk(d, "imm_control", ic, e.imm_ctrl);
                chk(d, "term_idx", ti, e.term);
                chk(d, "bus", bus, e.bus);
                chk(d, "busy", bz, e.is_done ? 0 : 1);
                chk(d, "done", dn, e.is_done ? 1 : 0);
                chk(d, "alu_op", ao, 32'(ALU_ADD));
                chk(d, "buff_en", be, 1);
            end
        end else if (bz != 0 && qsize(d) != 0) begin
            e = (d == 0) ? exp0[0] : exp1[0];
            if (!e.is_done) begin
                chk(d, "wait_muxA", ma, e.mux_a);
                chk(d, "wait_muxB", mb, e.mux_b);
                chk(d, "wait_imm_control", ic, e.imm_ctrl);
            end
        end
        if (ren != 0) begin
            for (int i = 0; i < 16; i++) if (ren[i]) rf[d][i] = bus;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, 32'(regs_en0), 32'(mux_a0), 32'(mux_b0), 32'(imm0), 32'(imm_ctrl0), 32'(buff_en0),
                32'(alu_op0), 32'(busy0), 32'(done0), 32'(done_prev0), 32'(term0));
            mon(1, 32'(regs_en1), 32'(mux_a1), 32'(mux_b1), 32'(imm1), 32'(imm_ctrl1), 32'(buff_en1),
                32'(alu_op1), 32'(busy1), 32'(done1), 32'(done_prev1), 32'(term1));
        end
        done_prev0 <= done0;
        done_prev1 <= done1;
    end

    task automatic wait_drain(input int d, input int budget);
        for (int i = 0; i < budget && qsize(d) != 0; i++) @(negedge clk);
        chk(d, "outstanding_events", qsize(d), 0);
        if (d == 0) exp0.delete();
        else        exp1.delete();
    endtask

    task automatic chk_quiet0(input string tag);
        chk(0, {tag, "_alu_op"}, 32'(alu_op0), 0);
        chk(0, {tag, "_muxA"}, 32'(mux_a0), 0);
        chk(0, {tag, "_muxB"}, 32'(mux_b0), 0);
        chk(0, {tag, "_regs_en"}, 32'(regs_en0), 0);
        chk(0, {tag, "_imm"}, 32'(imm0), 0);
        chk(0, {tag, "_imm_control"}, 32'(imm_ctrl0), 0);
        chk(0, {tag, "_buff_en"}, 32'(buff_en0), 0);
        chk(0, {tag, "_busy"}, 32'(busy0), 0);
        chk(0, {tag, "_done"}, 32'(done0), 0);
        chk(0, {tag, "_term_idx"}, 32'(term0), 0);
    endtask

    task automatic run_free(input int d);
        int n;
        n = (d == 0) ? NT0 : NT1;
        push_run(d, n, cyc + 1);
        if (d == 0) start = 1'b1;
        else        start1 = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
        wait_drain(d, n + 8);
    endtask

    // Step run on dut0; w[j] idle cycles precede each one-cycle step pulse.
    task automatic run_step(input bit rnd);
        int w[NT0];
        int p;
        p = cyc + 1;
        for (int j = 0; j < NT0; j++) begin
            w[j] = rnd ? int'($urandom_range(3, 1)) : ((j == 0) ? 1 : 2);
            if (j > 0) p = p + 1;
            p = p + w[j];
            push_write(0, j, p + 1);
        end
        push_done(0, NT0, p + 2);
        step_mode = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < NT0; j++) begin
            repeat (w[j]) @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        wait_drain(0, 8);
    endtask

    task automatic run_twice(input bit use_loop);
        push_run(0, NT0, cyc + 1);
        push_run(0, NT0, cyc + NT0 + 2);
        if (use_loop) loop = 1'b1;
        start = 1'b1;
        if (use_loop) begin
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 60 && qsize(0) > NT0; i++) @(negedge clk);
        chk(0, "second_run_started", 32'(qsize(0) <= NT0), 1);
        loop  = 1'b0;
        start = 1'b0;
        wait_drain(0, NT0 + 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) rf[d][i] = 0;
        repeat (3) @(negedge clk);
        chk_quiet0("reset");
        chk(1, "reset_regs_en", 32'(regs_en1), 0);
        chk(1, "reset_done", 32'(done1), 0);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet0("idle");

        run_free(0);
        @(negedge clk);
        chk(0, "done_hold", 32'(done0), 1);
        chk(0, "done_muxA", 32'(mux_a0), NT0 - 1);

        run_step(1'b0);
        repeat (3) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            @(negedge clk);
        end
        chk(0, "done_ignores_step", 32'(done0), 1);
        step_mode = 1'b0;

        run_twice(1'b1);
        run_twice(1'b0);

        for (int j = 0; j < 8; j++) push_write(0, j, cyc + 1 + j);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 reset = 1'b0;
        #1 chk_quiet0("async_reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet0("post_reset_idle");
        wait_drain(0, 2);
        run_free(0);

        run_free(1);
        @(negedge clk);
        chk(1, "done_hold", 32'(done1), 1);
        chk(1, "done_muxA", 32'(mux_a1), NT1 - 1);

        repeat (6) begin
            repeat ($urandom_range(4, 0)) @(negedge clk);
            if ($urandom_range(1, 0) == 1) run_step(1'b1);
            else                           run_free(0);
            step_mode = 1'b0;
        end

        repeat (4) @(negedge clk);
        chk(0, "final_queue", qsize(0), 0);
        chk(1, "final_queue", qsize(1), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Parametrised datapath sequencer that drives the register file, operand muxes, ALU and bus buffer to compute a Fibonacci sequence into consecutive registers.
- Generalises the fixed-length Fibonacci controller: register count, data width, selector width and term count are parameters.
- Adds a start/busy/done handshake, a single-step mode and a continuous loop mode.
- Sits between the top-level board controls and the CPU datapath; all outputs are Moore outputs of the state register and the term counter.

## Interface
- DATA_W, 16, width of `imm`
- NUM_REGS, 16, number of registers (width of `regs_en`); 3..2**SEL_W
- SEL_W, 5, operand mux select width (`muxA`, `muxB`)
- NUM_TERMS, NUM_REGS, terms to generate; 3..NUM_REGS
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; forces IDLE
- start  in  1  level, sampled each posedge; starts a run from IDLE or DONE
- step_mode  in  1  1 = each op waits for `step`
- step  in  1  level, sampled each posedge; advances one op in step mode
- loop  in  1  1 = restart automatically after DONE
- alu_op  out  8  ALU opcode
- muxA  out  SEL_W  operand A register select
- muxB  out  SEL_W  operand B register select
- regs_en  out  NUM_REGS  one-hot register write enable
- imm  out  DATA_W  immediate operand
- imm_control  out  1  1 = B operand taken from `imm`
- buff_en  out  1  bus buffer enable
- busy  out  1  run in progress
- done  out  1  run complete
- term_idx  out  SEL_W  current destination register index k

## Operation
- States: IDLE, CLEAR, SEED, ADD, DONE; counter k (SEL_W bits).
- IDLE: all outputs 0. start=1 -> CLEAR.
- CLEAR: write R0 = 0 + imm.
  - alu_op=ALU_ADD, muxA=0, muxB=0, imm=0, imm_control=1, regs_en=bit0, buff_en=1, k=0.
  - Next state SEED.
- SEED: write R1 = R0 + 1.
  - muxA=0, imm=1, imm_control=1, regs_en=bit1, buff_en=1, k=1.
  - Next state ADD with k=2.
- ADD: write Rk = R(k-2) + R(k-1).
  - muxA=k-2, muxB=k-1, imm=0, imm_control=0, regs_en=bit k, buff_en=1.
  - If k == NUM_TERMS-1: next state DONE. Otherwise k <= k+1.
- DONE:
  - Outputs: alu_op=ALU_ADD, muxA=NUM_TERMS-1, muxB=0, imm_control=0, regs_en=0, buff_en=1. The bus therefore shows the final term.
  - done=1, busy=0, k holds.
  - loop=1 -> CLEAR next cycle.
  - Otherwise stay in DONE; start=1 -> CLEAR.
- busy=1 in CLEAR, SEED and ADD only.
- Step mode:
  - In CLEAR/SEED/ADD with step_mode=1 and step=0: hold state and k; present mux/imm/alu outputs; regs_en=0.
  - With step=1: regs_en asserted that cycle and the state advances.
  - step_mode changes take effect on the next cycle.
  - step is ignored in IDLE and DONE.
- start while busy: ignored.
- Unused state encodings: outputs 0, next state IDLE.
- Arithmetic is the datapath's; the controller performs no data arithmetic. k increments are modulo 2**SEL_W but never exceed NUM_TERMS-1.

## Timing
- Reset value of every output: 0. State IDLE, k=0.
- Asynchronous assert takes effect immediately; outputs return to 0 without a clock.
- Free-running run (step_mode=0): start sampled at edge 0 -> CLEAR in cycle 1, SEED cycle 2, ADD cycles 3..NUM_TERMS, DONE from cycle NUM_TERMS+1.
  - Exactly NUM_TERMS write cycles, one register each.
- Each write is performed by the datapath on the posedge ending the cycle in which regs_en is high.
- Loop: DONE lasts 1 cycle (done pulse) then CLEAR. Period = NUM_TERMS+1 cycles.
- Reset mid-run: immediate IDLE. Registers already written are not cleared.
- start and step arriving in the same cycle in DONE: start wins (-> CLEAR).

## Structure
- Shared package `cpu_pkg`: ALU_ADD = 8'h05, other ALU opcodes, state encoding typedef (3-bit), register-count constants.
- Single module; no sub-module. An optional `one_hot_dec` (k -> regs_en) is the only natural split.
- Parameter legality is checked at elaboration: NUM_TERMS <= NUM_REGS <= 2**SEL_W and NUM_TERMS >= 3.

## Test plan
- Defaults, start pulse, step_mode=0, loop=0: regs_en sequence is 0x0001, 0x0002, 0x0004 … 0x8000 on 16 consecutive cycles.
  - Final cycle has muxA=13, muxB=14.
  - done rises on cycle 17; with the real datapath the bus reads 610.
- Step mode: step pulses on every third cycle.
  - One write per pulse; regs_en is 0 in between.
  - muxA/muxB remain stable while waiting.
  - done follows the 16th pulse.
- loop=1: done high for exactly 1 cycle every 17 cycles.
  - The second run repeats the identical regs_en sequence.
- Reset asserted during ADD at k=7:
  - All outputs are 0 asynchronously and the state is IDLE.
  - A subsequent start restarts at CLEAR with k=0.
- start held high throughout a run: no restart before DONE. The run then restarts from DONE because start=1.
- NUM_REGS=8, NUM_TERMS=5, SEL_W=3: regs_en is 0x01, 0x02, 0x04, 0x08, 0x10.
  - done on cycle 6; DONE drives muxA=4.
